// File: rtl/forwarding_pkg.sv
// rtl/forwarding_pkg.sv - forwarding bus entry type and operand register state
//
// Package forwarding:
//   t                : one forwarding bus entry {data_valid, data[31:0], address[4:0]}
//   NUM_FWD_DEFAULT  : default number of forwarding sources (EX, MEM, WB)
//   opreg_state_e    : ID/EX operand register occupancy (EMPTY, FULL)
package forwarding;

    typedef struct packed {
        logic        data_valid;
        logic [31:0] data;
        logic [4:0]  address;
    } t;

    localparam int NUM_FWD_DEFAULT = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } opreg_state_e;

endpackage

// File: rtl/operand_select.sv
// rtl/operand_select.sv - combinational resolver for one source operand
//
// Parameters:
//   NUM_FWD   : number of forwarding entries, index 0 is the youngest
// Ports:
//   addr      in  5        : source register address
//   rf_data   in  32       : register-file read data
//   fwd_i     in  NUM_FWD  : forwarding entries
//   value     out 32       : resolved operand value
//   hazard    out 1        : youngest matching producer has no data yet
//   forwarded out 1        : value was taken from a forwarding entry
module operand_select
    import forwarding::*;
#(
    parameter int NUM_FWD = NUM_FWD_DEFAULT
) (
    input  logic [4:0]         addr,
    input  logic [31:0]        rf_data,
    input  t     [NUM_FWD-1:0] fwd_i,
    output logic [31:0]        value,
    output logic               hazard,
    output logic               forwarded
);

    logic        match;
    logic        match_valid;
    logic [31:0] match_data;

    // Walk from oldest to youngest so the lowest matching index overwrites
    // the others. The data_valid of that entry alone decides the outcome,
    // an older valid copy of the same register is stale by definition.
    always_comb begin
        match       = 1'b0;
        match_valid = 1'b0;
        match_data  = 32'd0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_i[i].address == addr && fwd_i[i].address != 5'd0) begin
                match       = 1'b1;
                match_valid = fwd_i[i].data_valid;
                match_data  = fwd_i[i].data;
            end
        end
    end

    always_comb begin
        value     = rf_data;
        hazard    = 1'b0;
        forwarded = 1'b0;
        if (addr == 5'd0) begin
            value = 32'd0;
        end else if (match) begin
            if (match_valid) begin
                value     = match_data;
                forwarded = 1'b1;
            end else begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// rtl/operand_forward_unit.sv - ID/EX operand register with forwarding and load-use stall
//
// Optional statistics counters are enabled with the macro OPERAND_FWD_STATS_EN.
//
// Parameters:
//   NUM_FWD           : number of forwarding sources, index 0 youngest
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   flush_i           : drop the registered instruction, block capture
//   id_valid_i/id_ready_o : decode handshake
//   id_rs*_addr_i, id_rs*_used_i : source operand addresses and use flags
//   rf_rs*_data_i     : register-file read data
//   fwd_i             : forwarding entries
//   ex_valid_o/ex_ready_i : execute handshake
//   ex_rs*_o          : registered resolved operands
//   stall_o           : operand hazard present
//   fwd_count_o, stall_count_o : saturating statistics (macro only)
module operand_forward_unit
    import forwarding::*;
#(
    parameter int NUM_FWD = NUM_FWD_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic [4:0]         id_rs1_addr_i,
    input  logic [4:0]         id_rs2_addr_i,
    input  logic               id_rs1_used_i,
    input  logic               id_rs2_used_i,
    input  logic [31:0]        rf_rs1_data_i,
    input  logic [31:0]        rf_rs2_data_i,
    input  t     [NUM_FWD-1:0] fwd_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [31:0]        ex_rs1_o,
    output logic [31:0]        ex_rs2_o,
    output logic               stall_o
`ifdef OPERAND_FWD_STATS_EN
    ,
    output logic [31:0]        fwd_count_o,
    output logic [31:0]        stall_count_o
`endif
);

    opreg_state_e state;

    logic [31:0] val1, val2;
    logic        hz1, hz2;
    logic        fwd1, fwd2;
    logic        hazard, slot_free, capture;

    operand_select #(.NUM_FWD(NUM_FWD)) u_sel_rs1 (
        .addr      (id_rs1_addr_i),
        .rf_data   (rf_rs1_data_i),
        .fwd_i     (fwd_i),
        .value     (val1),
        .hazard    (hz1),
        .forwarded (fwd1)
    );

    operand_select #(.NUM_FWD(NUM_FWD)) u_sel_rs2 (
        .addr      (id_rs2_addr_i),
        .rf_data   (rf_rs2_data_i),
        .fwd_i     (fwd_i),
        .value     (val2),
        .hazard    (hz2),
        .forwarded (fwd2)
    );

    // A hazard on an operand the instruction does not read is harmless.
    assign hazard     = id_valid_i & ((id_rs1_used_i & hz1) | (id_rs2_used_i & hz2));
    assign stall_o    = hazard;
    assign slot_free  = (state == EMPTY) | ex_ready_i;
    assign id_ready_o = slot_free & ~hazard & ~flush_i;
    assign capture    = id_valid_i & id_ready_o;
    assign ex_valid_o = (state == FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= EMPTY;
        end else if (flush_i) begin
            state <= EMPTY;
        end else if (capture) begin
            state <= FULL;
        end else if (state == FULL && ex_ready_i) begin
            state <= EMPTY;
        end
    end

    // Operands move only on capture so a stalled execute stage sees stable values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_rs1_o <= 32'd0;
            ex_rs2_o <= 32'd0;
        end else if (capture) begin
            ex_rs1_o <= val1;
            ex_rs2_o <= val2;
        end
    end

`ifdef OPERAND_FWD_STATS_EN
    logic [1:0]  fwd_inc;
    logic [32:0] fwd_sum;

    assign fwd_inc = {1'b0, id_rs1_used_i & fwd1} + {1'b0, id_rs2_used_i & fwd2};
    assign fwd_sum = {1'b0, fwd_count_o} + {31'd0, fwd_inc};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_count_o <= 32'd0;
        end else if (capture) begin
            fwd_count_o <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_count_o <= 32'd0;
        end else if (hazard && !flush_i && stall_count_o != 32'hFFFF_FFFF) begin
            stall_count_o <= stall_count_o + 32'd1;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = fwd1 ^ fwd2;
`endif

endmodule

// File: doc/operand_forward_unit.md
# operand_forward_unit

Consumer end of the forwarding bus. It sits between decode and execute as the ID/EX operand register. For each source operand it picks the youngest matching `forwarding::t` entry or the register-file read, stalls decode when the matching producer has no data yet, and registers the resolved operands toward execute behind a valid/ready handshake.

## Interface
Parameters:
- `NUM_FWD`, 3: number of forwarding sources; index 0 is the youngest (EX), higher indices are older (MEM, WB).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `flush_i` in 1: discard the registered instruction and block capture this cycle.
- `id_valid_i` in 1: decode offers an instruction.
- `id_ready_o` out 1: this block accepts the offered instruction this cycle.
- `id_rs1_addr_i`, `id_rs2_addr_i` in 5 each: source register addresses.
- `id_rs1_used_i`, `id_rs2_used_i` in 1 each: the operand is actually read.
- `rf_rs1_data_i`, `rf_rs2_data_i` in 32 each: register-file read data, valid in the same cycle.
- `fwd_i` in NUM_FWD × `forwarding::t`: forwarding entries {data_valid, data[31:0], address[4:0]}.
- `ex_valid_o` out 1: the operand register holds an instruction.
- `ex_ready_i` in 1: execute consumes the instruction.
- `ex_rs1_o`, `ex_rs2_o` out 32 each: resolved operands.
- `stall_o` out 1: operand hazard present (combinational).
- `fwd_count_o`, `stall_count_o` out 32 each: present only with the macro described under Configuration.

## Operation
- **Per-operand resolution** (combinational), applied to rs1 and rs2 independently:
  - Address 0 → operand value 0, no hazard. Forwarding entries are ignored for this operand.
  - Otherwise, find the lowest index i where `fwd_i[i].address == addr` and `fwd_i[i].address != 0`. A match is taken whether or not `data_valid` is set.
  - Match with `data_valid` = 1 → operand is `fwd_i[i].data`.
  - Match with `data_valid` = 0 → hazard. Older matches are NOT consulted.
  - No match → operand is the register-file data.
- **Hazard signal**: `hazard = id_valid_i & ((rs1_used & hz1) | (rs2_used & hz2))`, and `stall_o = hazard`.
  - A hazard on an unused operand is ignored.
- **Output state**, two states:
  - EMPTY: `ex_valid_o` = 0.
  - FULL: `ex_valid_o` = 1.
- **Handshake signals**:
  - `slot_free = !ex_valid_o | ex_ready_i`
  - `id_ready_o = slot_free & !hazard & !flush_i`
  - `capture = id_valid_i & id_ready_o`
- **State transitions**, evaluated in priority order:
  - `flush_i` → EMPTY.
  - `capture` → FULL, operands loaded.
  - FULL & `ex_ready_i` → EMPTY (a bubble is inserted while a hazard persists).
  - Otherwise hold.
- Operand registers change only on `capture`. While FULL and `ex_ready_i` = 0 they hold their values exactly.
- Simultaneous `flush_i` and `capture` conditions: flush wins, nothing is captured, and decode sees `id_ready_o` = 0.
- Reset value of every output: `ex_valid_o` 0, `ex_rs1_o`/`ex_rs2_o` 0, counters 0. Reset asserted mid-operation clears all outputs immediately (asynchronous).

## Timing
- Latency: an instruction accepted at edge N appears on `ex_valid_o`/`ex_rs*_o` after edge N (one cycle).
- `fwd_i` and `rf_*` are sampled only in the capture cycle. Later changes do not affect registered operands.
- `id_ready_o` and `stall_o` depend combinationally on `fwd_i`, `id_*`, `ex_ready_i` and `flush_i`. There is no path from `ex_valid_o` back into `ex_ready_i`.
- Throughput: one instruction per cycle when there is no hazard and `ex_ready_i` = 1.
- A stall lasts exactly as long as the youngest matching entry has `data_valid` = 0. Capture happens in the first cycle it reads 1, or in the first cycle the entry no longer matches.

## Configuration
- `OPERAND_FWD_STATS_EN` defined:
  - `fwd_count_o` adds the number of forwarded operands (0, 1 or 2) for each capture. Address-0 and unused operands do not count.
  - `stall_count_o` increments each cycle `hazard & !flush_i`.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Macro undefined: both ports and both counters are absent. No other behaviour changes.

## Structure
- The existing `forwarding` package keeps `forwarding::t` unchanged.
- Add `forwarding::NUM_FWD_DEFAULT = 3` and the state enum `forwarding::opreg_state_e {EMPTY, FULL}` to that package.
- Sub-module `operand_select`: purely combinational per-operand resolver (inputs: addr, rf data, `fwd_i`; outputs: value, hazard, forwarded). It is instantiated twice.

## Test plan
- **Youngest match wins**: rs1=5, `fwd_i[0]`={1,0xDEADBEEF,5}, `fwd_i[1]`={1,0x11111111,5} → `ex_rs1_o`=0xDEADBEEF and `ex_valid_o`=1 one cycle later.
- **Load-use stall**: rs2=7 used, `fwd_i[0]`={0,x,7} for 2 cycles, then {1,0x42,7} → `stall_o`=1 and `id_ready_o`=0 for 2 cycles, capture on the 3rd, `ex_rs2_o`=0x42. With the macro, `stall_count_o`=2 and `fwd_count_o`=1.
- **x0 and unused operands**:
  - rs1=0 with `fwd_i[0]`={1,0xFFFF,0} → `ex_rs1_o`=0.
  - rs2_used=0 with `fwd_i[0]`={0,x,rs2} → no stall; rf data is captured.
- **Back-pressure**: FULL, `ex_ready_i`=0, new `id_valid_i` → `id_ready_o`=0 and outputs unchanged for 3 cycles. `ex_ready_i`=1 → new operands appear on the next edge.
- **Flush**: FULL with `flush_i`=1 and `id_valid_i`=1 → `ex_valid_o`=0 next cycle and nothing captured.
- **Asynchronous reset**: `rst_ni` low mid-stall → all outputs 0 before the next clock edge.
